// File: rtl/stream_slice_pkg.sv
// Shared types and the elaboration-time parameter check for the stream slice pipe.
package stream_slice_pkg;

    typedef enum logic {
        MODE_UNPACK = 1'b0,
        MODE_PACK   = 1'b1
    } mode_e;

    // True when the width/slice parameter set describes a legal transform.
    function automatic bit params_ok(
        input int word_w,
        input int f1_w,
        input int f2_w,
        input int out_slice,
        input int in_slice,
        input int cnt_w
    );
        return (word_w >= 1) && (f1_w >= 1) && (f2_w >= 1) && (cnt_w >= 1) &&
               (out_slice >= 1) && (in_slice >= 1) && (f1_w + f2_w <= word_w);
    endfunction

endpackage

// File: rtl/stream_slice_rev.sv
// Combinational slice reversal: LSB-first S-bit chunks are laid out MSB-first.
// The last chunk (at the input MSB end) may be narrower than S.
module stream_slice_rev
    import stream_slice_pkg::*;
#(
    parameter int W = 8,
    parameter int S = 1
) (
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);

    localparam int NCH = (W + S - 1) / S;

    // Every chunk before chunk k is a full S bits, so chunk k lands at W-1-k*S.
    for (genvar k = 0; k < NCH; k++) begin : g_chunk
        localparam int LEN = ((W - k * S) < S) ? (W - k * S) : S;
        assign y_o[W-1-k*S -: LEN] = x_i[k*S +: LEN];
    end

endmodule

// File: rtl/stream_slice_pipe.sv
// Two-stage handshaked pipe computing the nested streaming transform
// {<< OUT_SLICE {{<< IN_SLICE {f1}}, f2}} in unpack or pack direction per beat.
module stream_slice_pipe
    import stream_slice_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int F1_W      = 9,
    parameter int F2_W      = 7,
    parameter int OUT_SLICE = 5,
    parameter int IN_SLICE  = 3,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
    output logic [WORD_W-1:0] out_data,
    output logic [CNT_W-1:0]  beat_cnt
);

    localparam int FW = F1_W + F2_W;

    if (!params_ok(WORD_W, F1_W, F2_W, OUT_SLICE, IN_SLICE, CNT_W)) begin : g_param_err
        $fatal(1, "stream_slice_pipe: illegal width or slice parameters");
    end

    mode_e             in_mode_e;
    logic              s1_valid_q;
    mode_e             s1_mode_q;
    logic [FW-1:0]     s1_data_q;
    logic [FW-1:0]     s1_data_d;
    logic              out_valid_q;
    mode_e             out_mode_q;
    logic [WORD_W-1:0] out_data_q;
    logic [WORD_W-1:0] out_data_d;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic              s1_take;
    logic              s2_take;

    logic [WORD_W-1:0] word_rev;
    logic [F1_W-1:0]   f1_in_rev;
    logic [F1_W-1:0]   f1_out_rev;
    logic [FW-1:0]     pack_rev;

    assign in_mode_e = mode_e'(in_mode);

    // Stage 1 datapath: unpack keeps the top FW bits of the outer reversal,
    // pack applies the inner reversal to f1 first. Either way S1 holds FW bits.
    stream_slice_rev #(.W(WORD_W), .S(OUT_SLICE)) u_rev_word (
        .x_i (in_data),
        .y_o (word_rev)
    );

    stream_slice_rev #(.W(F1_W), .S(IN_SLICE)) u_rev_f1_pack (
        .x_i (in_data[FW-1:F2_W]),
        .y_o (f1_in_rev)
    );

    // Select the stage-1 intermediate for the incoming beat's mode.
    always_comb begin
        s1_data_d = word_rev[WORD_W-1 -: FW];
        if (in_mode_e == MODE_PACK) begin
            s1_data_d = {f1_in_rev, in_data[F2_W-1:0]};
        end
    end

    // Stage 2 datapath: finish with the remaining reversal and justify the result.
    stream_slice_rev #(.W(F1_W), .S(IN_SLICE)) u_rev_f1_unpack (
        .x_i (s1_data_q[FW-1:F2_W]),
        .y_o (f1_out_rev)
    );

    stream_slice_rev #(.W(FW), .S(OUT_SLICE)) u_rev_pack (
        .x_i (s1_data_q),
        .y_o (pack_rev)
    );

    // Right-justify unpack results, left-justify pack results, zero elsewhere.
    always_comb begin
        out_data_d = '0;
        if (s1_mode_q == MODE_PACK) begin
            out_data_d[WORD_W-1 -: FW] = pack_rev;
        end else begin
            out_data_d[FW-1:0] = {f1_out_rev, s1_data_q[F2_W-1:0]};
        end
    end

    assign s2_take  = !out_valid_q || out_ready;
    assign s1_take  = !s1_valid_q || s2_take;
    assign in_ready = s1_take;

    // Pipeline registers and saturating beat counter; reset wins over handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= MODE_UNPACK;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_mode_q  <= MODE_UNPACK;
            out_data_q  <= '0;
            beat_cnt_q  <= '0;
        end else begin
            if (s1_take) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_mode_q <= in_mode_e;
                    s1_data_q <= s1_data_d;
                end
            end
            if (s2_take) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_mode_q <= s1_mode_q;
                    out_data_q <= out_data_d;
                end
            end
            if (out_valid_q && out_ready && (beat_cnt_q != '1)) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_mode  = out_mode_q;
    assign out_data  = out_data_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_stream_slice_pipe.sv
// Self-checking bench for stream_slice_pipe: default and alternate parameter sets,
// scoreboarded against a chunk-list model of the nested streaming transform.
module tb_stream_slice_pipe;

    localparam int A_W = 32, A_F1 = 9, A_F2 = 7, A_OS = 5, A_IS = 3, A_CNT = 16;
    localparam int B_W = 24, B_F1 = 8, B_F2 = 8, B_OS = 4, B_IS = 1, B_CNT = 4;

    typedef struct {
        logic        mode;
        logic [63:0] exp;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    always #5 clk = ~clk;

    // Free-running cycle count used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // DUT A: default parameters.
    logic             a_in_valid = 1'b0;
    logic             a_in_ready;
    logic             a_in_mode = 1'b0;
    logic [A_W-1:0]   a_in_data = '0;
    logic             a_out_valid;
    logic             a_out_ready;
    logic             a_out_mode;
    logic [A_W-1:0]   a_out_data;
    logic [A_CNT-1:0] a_beat_cnt;
    logic             a_bp_en = 1'b0;
    logic             a_rdy = 1'b1;
    logic             a_rnd = 1'b1;

    assign a_out_ready = a_bp_en ? a_rnd : a_rdy;

    stream_slice_pipe #(
        .WORD_W(A_W), .F1_W(A_F1), .F2_W(A_F2),
        .OUT_SLICE(A_OS), .IN_SLICE(A_IS), .CNT_W(A_CNT)
    ) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_mode(a_out_mode),
        .out_data(a_out_data), .beat_cnt(a_beat_cnt)
    );

    // DUT B: alternate geometry and a narrow counter so saturation is reachable.
    logic             b_in_valid = 1'b0;
    logic             b_in_ready;
    logic             b_in_mode = 1'b0;
    logic [B_W-1:0]   b_in_data = '0;
    logic             b_out_valid;
    logic             b_out_ready;
    logic             b_out_mode;
    logic [B_W-1:0]   b_out_data;
    logic [B_CNT-1:0] b_beat_cnt;

    assign b_out_ready = 1'b1;

    stream_slice_pipe #(
        .WORD_W(B_W), .F1_W(B_F1), .F2_W(B_F2),
        .OUT_SLICE(B_OS), .IN_SLICE(B_IS), .CNT_W(B_CNT)
    ) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mode(b_out_mode),
        .out_data(b_out_data), .beat_cnt(b_beat_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] msk(input int n);
        if (n >= 64) return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

    // Build the result by appending chunks in LSB-first order; the first chunk ends up on top.
    function automatic logic [63:0] rev_m(input logic [63:0] x, input int w, input int s);
        logic [63:0] r;
        int len;
        r = '0;
        for (int st = 0; st < w; st += s) begin
            len = ((w - st) < s) ? (w - st) : s;
            r = (r << len) | ((x >> st) & msk(len));
        end
        return r;
    endfunction

    function automatic logic [63:0] model(input logic m, input logic [63:0] d, input int w,
                                          input int f1w, input int f2w, input int osl, input int isl);
        int fw;
        logic [63:0] t, u, f1, f2;
        fw = f1w + f2w;
        if (!m) begin
            t  = rev_m(d & msk(w), w, osl);
            u  = (t >> (w - fw)) & msk(fw);
            f1 = rev_m(u >> f2w, f1w, isl);
            return (f1 << f2w) | (u & msk(f2w));
        end
        f1 = (d >> f2w) & msk(f1w);
        f2 = d & msk(f2w);
        t  = (rev_m(f1, f1w, isl) << f2w) | f2;
        return rev_m(t, fw, osl) << (w - fw);
    endfunction

    exp_t            a_q[$];
    exp_t            b_q[$];
    logic [A_W-1:0]  a_log[$];
    logic [B_W-1:0]  b_log[$];
    int unsigned     a_nout = 0;
    int unsigned     b_nout = 0;
    bit              a_lat_chk = 1'b0;
    bit              a_stall = 1'b0;
    logic [A_W-1:0]  a_hold_d;
    logic            a_hold_m;

    // Random backpressure for DUT A, updated just after each active edge.
    always @(posedge clk) begin
        #1;
        a_rnd = ($urandom_range(0, 99) < 65);
    end

    // DUT A scoreboard: handshakes are observed on the falling edge ahead of the edge that completes them.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (rst) begin
            a_q.delete();
            a_nout  = 0;
            a_stall = 1'b0;
        end else begin
            if (a_stall) begin
                check("a_hold_valid", a_out_valid, 1);
                check("a_hold_data", a_out_data, a_hold_d);
                check("a_hold_mode", a_out_mode, a_hold_m);
            end
            if (a_out_valid && a_out_ready) begin
                a_nout++;
                a_log.push_back(a_out_data);
                check("a_out_pending", (a_q.size() > 0), 1);
                if (a_q.size() > 0) begin
                    e = a_q.pop_front();
                    check("a_data", a_out_data, e.exp);
                    check("a_mode", a_out_mode, e.mode);
                    if (a_lat_chk) check("a_latency", cyc - e.cyc, 2);
                end
            end
            if (a_in_valid && a_in_ready) begin
                e.mode = a_in_mode;
                e.exp  = model(a_in_mode, 64'(a_in_data), A_W, A_F1, A_F2, A_OS, A_IS);
                e.cyc  = cyc;
                a_q.push_back(e);
            end
            a_stall  = a_out_valid && !a_out_ready;
            a_hold_d = a_out_data;
            a_hold_m = a_out_mode;
        end
    end

    // DUT B scoreboard.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (rst) begin
            b_q.delete();
            b_nout = 0;
        end else begin
            if (b_out_valid && b_out_ready) begin
                b_nout++;
                b_log.push_back(b_out_data);
                check("b_out_pending", (b_q.size() > 0), 1);
                if (b_q.size() > 0) begin
                    e = b_q.pop_front();
                    check("b_data", b_out_data, e.exp);
                    check("b_mode", b_out_mode, e.mode);
                end
            end
            if (b_in_valid && b_in_ready) begin
                e.mode = b_in_mode;
                e.exp  = model(b_in_mode, 64'(b_in_data), B_W, B_F1, B_F2, B_OS, B_IS);
                e.cyc  = cyc;
                b_q.push_back(e);
            end
        end
    end

    task automatic a_send(input logic m, input logic [A_W-1:0] d);
        int unsigned guard = 0;
        a_in_valid = 1'b1;
        a_in_mode  = m;
        a_in_data  = d;
        @(negedge clk);
        while (!a_in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) check("a_send_timeout", guard, 0);
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic b_send(input logic m, input logic [B_W-1:0] d);
        int unsigned guard = 0;
        b_in_valid = 1'b1;
        b_in_mode  = m;
        b_in_data  = d;
        @(negedge clk);
        while (!b_in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) check("b_send_timeout", guard, 0);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned guard = 0;
        @(negedge clk);
        while ((a_q.size() != 0 || a_out_valid || b_q.size() != 0 || b_out_valid) && guard < 500) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 500) check("drain_timeout", guard, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [A_W-1:0] w;
        logic [A_W-1:0] v;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("a_rst_out_valid", a_out_valid, 0);
        check("a_rst_out_data", a_out_data, 0);
        check("a_rst_out_mode", a_out_mode, 0);
        check("a_rst_beat_cnt", a_beat_cnt, 0);
        check("a_rst_in_ready", a_in_ready, 1);
        check("b_rst_out_valid", b_out_valid, 0);
        check("b_rst_in_ready", b_in_ready, 1);

        // One-hot unpack sweep with latency tracking.
        a_log.delete();
        a_lat_chk = 1'b1;
        for (int i = 0; i < A_W; i++) begin
            w = '0;
            w[i] = 1'b1;
            a_send(1'b0, w);
        end
        drain();
        a_lat_chk = 1'b0;
        check("onehot_count", a_log.size(), 32);
        v = a_log[0];
        check("onehot0_f1", v[15:7], 9'b000010000);
        check("onehot0_f2", v[6:0], 0);
        v = a_log[5];
        check("onehot5_f2", v[6:0], 7'b1000000);
        v = a_log[9];
        check("onehot9_f1", v[15:7], 9'b000001000);
        v = a_log[10];
        check("onehot10_f2", v[6:0], 7'b0000010);
        check("onehot31_data", a_log[31], 0);
        check("onehot_beat_cnt", a_beat_cnt, a_nout);

        // Directed pack beat.
        a_log.delete();
        a_send(1'b1, {16'h0, 9'b000010000, 7'b0});
        drain();
        check("pack_directed", a_log[0], 32'h0004_0000);

        // Back-to-back alternating modes, no backpressure.
        a_lat_chk = 1'b1;
        for (int i = 0; i < 20; i++) a_send(1'(i % 2), $urandom());
        drain();
        a_lat_chk = 1'b0;
        check("alt_beat_cnt", a_beat_cnt, a_nout);

        // Random traffic under random backpressure.
        a_bp_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            a_send(1'($urandom_range(0, 1)), $urandom());
        end
        a_bp_en = 1'b0;
        drain();
        check("rand_beat_cnt", a_beat_cnt, a_nout);

        // Fill both stages under a stall, then reset over a live handshake.
        a_rdy = 1'b0;
        a_in_valid = 1'b1;
        a_in_mode  = 1'b0;
        a_in_data  = $urandom();
        repeat (2) @(posedge clk);
        #1;
        check("full_in_ready", a_in_ready, 0);
        check("full_out_valid", a_out_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_in_valid = 1'b0;
        a_rdy = 1'b1;
        check("midrst_out_valid", a_out_valid, 0);
        check("midrst_beat_cnt", a_beat_cnt, 0);
        check("midrst_in_ready", a_in_ready, 1);
        for (int i = 0; i < 4; i++) a_send(1'(i % 2), $urandom());
        drain();
        check("post_rst_beat_cnt", a_beat_cnt, 4);

        // Alternate geometry: all one-hot inputs in both modes, counter saturates.
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < B_W; i++) begin
                logic [B_W-1:0] bw;
                bw = '0;
                bw[i] = 1'b1;
                b_send(1'(m), bw);
            end
        end
        drain();
        check("b_count", b_log.size(), 2 * B_W);
        check("b_beat_cnt_sat", b_beat_cnt, (b_nout > 15) ? 15 : b_nout);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
